boot_data_sender: RTL

// Host-side initiator of the 32-bit boot-data req/ack handshake. Packs a byte stream (SD/SPI reader)

---
 rtl/boot_data_pkg.sv | 27 ++
 rtl/boot_word_packer.sv | 59 +++++
 rtl/boot_data_sender.sv | 108 ++++++++++
 3 files changed

// File: rtl/boot_data_pkg.sv
// Shared types and constants for the boot-data sender and its bootloader-side models.
// The cycle helper marks the states that run the shared reset-pulse / ack-timeout counter.
package boot_data_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    FILL,
    REQ,
    REL,
    DONE,
    ERROR,
    ABORT
  } boot_state_e;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = WORD_BYTES * BYTE_W;

  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'(WORD_BYTES - 1);

  function automatic logic counts_cycles(input boot_state_e s);
    return s inside {RST, REQ, REL, ABORT};
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs source bytes big-endian into a 32-bit word. After byte_last it stops reading
// the source and fills the remaining lanes with PAD_BYTE, one lane per cycle.
module boot_word_packer
  import boot_data_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic [BYTE_W-1:0] byte_data_i,
  input  logic              byte_valid_i,
  input  logic              byte_last_i,
  output logic              byte_ready_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [1:0]        lane_q, lane_d;
  logic              pad_q, pad_d;
  logic              take;
  logic [BYTE_W-1:0] in_byte;

  assign take         = enable_i & (pad_q | byte_valid_i);
  assign in_byte      = pad_q ? PAD_BYTE : byte_data_i;
  assign byte_ready_o = enable_i & ~pad_q;
  assign word_valid_o = take & (lane_q == LANE_LAST);
  assign word_o       = shift_q;

  always_comb begin
    shift_d = shift_q;
    lane_d  = lane_q;
    pad_d   = pad_q;
    if (clear_i) begin
      shift_d = '0;
      lane_d  = LANE_FIRST;
      pad_d   = 1'b0;
    end else if (take) begin
      shift_d = {shift_q[WORD_W-BYTE_W-1:0], in_byte};
      lane_d  = lane_q + 2'd1;
      if (byte_valid_i && byte_last_i) pad_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      lane_q  <= LANE_FIRST;
      pad_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      lane_q  <= lane_d;
      pad_q   <= pad_d;
    end
  end

endmodule

// File: rtl/boot_data_sender.sv
// Host-side initiator of the 32-bit boot-data req/ack handshake: resets the loader,
// streams packed words to it, counts acks and flags an ack timeout.
module boot_data_sender
  import boot_data_pkg::*;
#(
  parameter int unsigned WORD_COUNT   = 14336,
  parameter logic [7:0]  PAD_BYTE     = 8'hFF,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic [31:0] host_bootdata,
  output logic        host_bootdata_req,
  input  logic        host_bootdata_ack,
  output logic        host_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_sent
);

  localparam logic [15:0] WORDS_LAST = 16'(WORD_COUNT);
  localparam logic [15:0] RST_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(ACK_TIMEOUT - 1);

  boot_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] words_q, words_d;
  logic        pack_clear;
  logic        word_valid;

  boot_word_packer #(.PAD_BYTE(PAD_BYTE)) u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_i     (pack_clear),
    .enable_i    (state_q == FILL),
    .byte_data_i (byte_data),
    .byte_valid_i(byte_valid),
    .byte_last_i (byte_last),
    .byte_ready_o(byte_ready),
    .word_o      (host_bootdata),
    .word_valid_o(word_valid)
  );

  // abort overrides everything outside IDLE, including a simultaneous start or ack
  always_comb begin
    state_d    = state_q;
    words_d    = words_q;
    pack_clear = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = ABORT;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start && !abort) begin
            state_d    = RST;
            words_d    = '0;
            pack_clear = 1'b1;
          end
        end
        RST:   if (cnt_q == RST_LAST) state_d = FILL;
        FILL:  if (word_valid) state_d = REQ;
        REQ: begin
          if (host_bootdata_ack) begin
            state_d = REL;
            words_d = words_q + 16'd1;
          end else if (cnt_q == TO_LAST) begin
            state_d = ERROR;
          end
        end
        REL: begin
          if (!host_bootdata_ack) state_d = (words_q == WORDS_LAST) ? DONE : FILL;
          else if (cnt_q == TO_LAST) state_d = ERROR;
        end
        ABORT: if (cnt_q == RST_LAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    cnt_d = (state_d != state_q || !counts_cycles(state_q)) ? '0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
    end
  end

  assign host_bootdata_req = (state_q == REQ);
  assign host_reset        = state_q inside {RST, ABORT};
  assign busy              = state_q inside {RST, FILL, REQ, REL, ABORT};
  assign done              = (state_q == DONE);
  assign error             = (state_q == ERROR);
  assign words_sent        = words_q;

endmodule
